// File: rtl/vfu_result_wb_arbiter_if.sv
// Lane result write-back bus: three functional-unit result ports in, one VRF write port out.
// The master modport is the FU/VRF side; the slave modport is the arbiter.
interface vfu_result_wb_arbiter_if #(
   parameter int  NrVInsn   = 8,
   parameter type vaddr_t   = logic,
   parameter int  DataWidth = 64
);
   localparam int IdWidth = (NrVInsn > 1) ? $clog2(NrVInsn) : 1;

   typedef logic [IdWidth-1:0]     vid_t;
   typedef logic [DataWidth-1:0]   elen_t;
   typedef logic [DataWidth/8-1:0] strb_t;

   logic [2:0]          src_req_i;
   vid_t   [2:0]        src_id_i;
   vaddr_t [2:0]        src_addr_i;
   elen_t  [2:0]        src_wdata_i;
   strb_t  [2:0]        src_be_i;
   logic [2:0]          src_gnt_o;

   logic                vrf_req_o;
   vid_t                vrf_id_o;
   vaddr_t              vrf_addr_o;
   elen_t               vrf_wdata_o;
   strb_t               vrf_be_o;
   logic                vrf_gnt_i;
   logic [1:0]          vrf_src_o;

   logic [NrVInsn-1:0]  wb_pending_o;

   modport slave (
      input  src_req_i, src_id_i, src_addr_i, src_wdata_i, src_be_i, vrf_gnt_i,
      output src_gnt_o, vrf_req_o, vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o,
             vrf_src_o, wb_pending_o
   );

   modport master (
      output src_req_i, src_id_i, src_addr_i, src_wdata_i, src_be_i, vrf_gnt_i,
      input  src_gnt_o, vrf_req_o, vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o,
             vrf_src_o, wb_pending_o
   );
endinterface

// File: rtl/vfu_result_wb_arbiter.sv
// Per-lane result write-back: one-entry buffers for ALU/MFPU/TMAC results, round-robin
// onto the single VRF write port, plus an in-flight instruction ID mask.
module vfu_result_wb_arbiter #(
   parameter int  NrVInsn   = 8,
   parameter type vaddr_t   = logic,
   parameter int  DataWidth = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   vfu_result_wb_arbiter_if.slave  wb
);
   localparam int NrSrc   = 3;
   localparam int IdWidth = (NrVInsn > 1) ? $clog2(NrVInsn) : 1;

   typedef logic [IdWidth-1:0]     vid_t;
   typedef logic [DataWidth-1:0]   elen_t;
   typedef logic [DataWidth/8-1:0] strb_t;

   logic [NrSrc-1:0]   valid_reg;
   logic [NrSrc-1:0]   valid_next;
   vid_t               id_reg    [NrSrc];
   vaddr_t             addr_reg  [NrSrc];
   elen_t              wdata_reg [NrSrc];
   strb_t              be_reg    [NrSrc];

   logic [1:0]         rr_reg;
   logic               lock_reg;
   logic [1:0]         lock_sel_reg;

   logic [1:0]         rr_next;
   logic [1:0]         rr_prev;
   logic [1:0]         rr_sel;
   logic [1:0]         sel;
   logic               vrf_req;
   logic               handshake;
   logic [NrSrc-1:0]   drain;
   logic [NrSrc-1:0]   gnt;
   logic [NrVInsn-1:0] pending;

   assign rr_next = (rr_reg == 2'd2) ? 2'd0 : rr_reg + 2'd1;
   assign rr_prev = (rr_reg == 2'd0) ? 2'd2 : rr_reg - 2'd1;

   // Lowest-priority candidate first so the one nearest rr_reg wins.
   always_comb begin
      rr_sel = rr_reg;
      if (valid_reg[rr_prev]) rr_sel = rr_prev;
      if (valid_reg[rr_next]) rr_sel = rr_next;
      if (valid_reg[rr_reg])  rr_sel = rr_reg;
   end

   // A stalled write keeps its source even if an earlier-priority buffer fills meanwhile.
   assign sel       = lock_reg ? lock_sel_reg : rr_sel;
   assign vrf_req   = |valid_reg;
   assign handshake = vrf_req && wb.vrf_gnt_i;

   for (genvar gi = 0; gi < NrSrc; gi++) begin : g_buf
      assign drain[gi]      = handshake && (sel == 2'(gi));
      assign gnt[gi]        = wb.src_req_i[gi] && (!valid_reg[gi] || drain[gi]);
      assign valid_next[gi] = gnt[gi] || (valid_reg[gi] && !drain[gi]);

      always_ff @(posedge clk_i) begin
         if (gnt[gi]) begin
            id_reg[gi]    <= wb.src_id_i[gi];
            addr_reg[gi]  <= wb.src_addr_i[gi];
            wdata_reg[gi] <= wb.src_wdata_i[gi];
            be_reg[gi]    <= wb.src_be_i[gi];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_reg    <= '0;
         rr_reg       <= 2'd0;
         lock_reg     <= 1'b0;
         lock_sel_reg <= 2'd0;
      end else begin
         valid_reg    <= valid_next;
         lock_reg     <= vrf_req && !wb.vrf_gnt_i;
         lock_sel_reg <= sel;
         if (handshake) begin
            rr_reg <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
         end
      end
   end

   for (genvar gi = 0; gi < NrVInsn; gi++) begin : g_pending
      logic [NrSrc-1:0] hit;
      for (genvar gj = 0; gj < NrSrc; gj++) begin : g_hit
         assign hit[gj] = valid_reg[gj] && (id_reg[gj] == IdWidth'(gi));
      end
      assign pending[gi] = |hit;
   end

   assign wb.src_gnt_o    = gnt;
   assign wb.vrf_req_o    = vrf_req;
   assign wb.vrf_id_o     = id_reg[sel];
   assign wb.vrf_addr_o   = addr_reg[sel];
   assign wb.vrf_wdata_o  = wdata_reg[sel];
   assign wb.vrf_be_o     = be_reg[sel];
   assign wb.vrf_src_o    = sel;
   assign wb.wb_pending_o = pending;
endmodule

// File: tb/tb_vfu_result_wb_arbiter.sv
// Directed bench for the lane write-back arbiter with a per-source scoreboard of accepted
// results that is checked against every VRF write handshake.
module tb_vfu_result_wb_arbiter;
   localparam int NrVInsn   = 8;
   localparam int DataWidth = 64;

   typedef logic [7:0] addr_t;
   typedef struct packed {
      logic [2:0]  id;
      addr_t       addr;
      logic [63:0] data;
      logic [7:0]  be;
   } ent_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   exp_src     = 0;
   ent_t q0[$];
   ent_t q1[$];
   ent_t q2[$];
   ent_t ent;

   always #5 clk = ~clk;

   vfu_result_wb_arbiter_if #(
      .NrVInsn(NrVInsn), .vaddr_t(addr_t), .DataWidth(DataWidth)
   ) bus ();

   vfu_result_wb_arbiter #(
      .NrVInsn(NrVInsn), .vaddr_t(addr_t), .DataWidth(DataWidth)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .wb     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_src(input logic [1:0] s, input logic [2:0] id, input addr_t addr,
                          input logic [63:0] data, input logic [7:0] be);
      bus.src_id_i[s]    = id;
      bus.src_addr_i[s]  = addr;
      bus.src_wdata_i[s] = data;
      bus.src_be_i[s]    = be;
   endtask

   function automatic int depth(input logic [1:0] s);
      case (s)
         2'd0:    return q0.size();
         2'd1:    return q1.size();
         2'd2:    return q2.size();
         default: return 0;
      endcase
   endfunction

   function automatic void push(input logic [1:0] s, input ent_t e);
      case (s)
         2'd0:    q0.push_back(e);
         2'd1:    q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction

   function automatic ent_t pop(input logic [1:0] s);
      case (s)
         2'd0:    return q0.pop_front();
         2'd1:    return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   function automatic ent_t peek(input logic [1:0] s);
      case (s)
         2'd0:    return q0[0];
         2'd1:    return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic clear_sb();
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   // Called at the negative edge: retire a VRF write against the scoreboard, then record
   // every result accepted this cycle.
   task automatic score();
      ent_t e;
      logic [1:0] s;
      if (bus.vrf_req_o && bus.vrf_gnt_i) begin
         s = bus.vrf_src_o;
         chk("sb_has_entry", 64'(depth(s) > 0), 64'(1));
         if (depth(s) > 0) begin
            e = pop(s);
            chk("wr_id",   64'(bus.vrf_id_o),   64'(e.id));
            chk("wr_addr", 64'(bus.vrf_addr_o), 64'(e.addr));
            chk("wr_data", bus.vrf_wdata_o,     e.data);
            chk("wr_be",   64'(bus.vrf_be_o),   64'(e.be));
            $display("write src=%0d id=%0d addr=%02h data=%016h be=%02h",
                     s, bus.vrf_id_o, bus.vrf_addr_o, bus.vrf_wdata_o, bus.vrf_be_o);
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (bus.src_gnt_o[i]) begin
            push(2'(i), {bus.src_id_i[i], bus.src_addr_i[i], bus.src_wdata_i[i], bus.src_be_i[i]});
         end
      end
   endtask

   task automatic tick();
      score();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.src_req_i = '0;
      bus.vrf_gnt_i = 1'b0;
      for (int s = 0; s < 3; s++) set_src(2'(s), 3'd0, 8'h00, 64'h0, 8'h00);

      // Reset state, with requests present so the acceptance path is visible.
      bus.src_req_i = 3'b101;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_vrf_req", 64'(bus.vrf_req_o),    64'(0));
      chk("rst_vrf_src", 64'(bus.vrf_src_o),    64'(0));
      chk("rst_pending", 64'(bus.wb_pending_o), 64'(0));
      chk("rst_src_gnt", 64'(bus.src_gnt_o),    64'(3'b101));
      bus.src_req_i = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single ALU request.
      set_src(2'd0, 3'd2, 8'h10, 64'hDEAD, 8'hFF);
      bus.src_req_i = 3'b001;
      @(negedge clk);
      chk("a_gnt",     64'(bus.src_gnt_o),    64'(3'b001));
      chk("a_req_c0",  64'(bus.vrf_req_o),    64'(0));
      chk("a_pend_c0", 64'(bus.wb_pending_o), 64'(0));
      tick();
      bus.src_req_i = '0;
      @(negedge clk);
      chk("a_req",  64'(bus.vrf_req_o),    64'(1));
      chk("a_src",  64'(bus.vrf_src_o),    64'(0));
      chk("a_id",   64'(bus.vrf_id_o),     64'(2));
      chk("a_addr", 64'(bus.vrf_addr_o),   64'(8'h10));
      chk("a_data", bus.vrf_wdata_o,       64'hDEAD);
      chk("a_be",   64'(bus.vrf_be_o),     64'(8'hFF));
      chk("a_pend", 64'(bus.wb_pending_o), 64'(8'h04));
      tick();
      bus.vrf_gnt_i = 1'b1;
      @(negedge clk);
      chk("a_pend_hold", 64'(bus.wb_pending_o), 64'(8'h04));
      tick();
      @(negedge clk);
      chk("a_req_done",  64'(bus.vrf_req_o),    64'(0));
      chk("a_pend_done", 64'(bus.wb_pending_o), 64'(0));
      tick();

      // Restart arbitration from ALU for the continuous-traffic run.
      rst_n = 1'b0;
      clear_sb();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // All three sources request every cycle with the VRF always accepting.
      bus.vrf_gnt_i = 1'b1;
      exp_src = 0;
      for (int k = 0; k < 10; k++) begin
         for (int s = 0; s < 3; s++) begin
            set_src(2'(s), 3'(k + s), 8'(16 * s + k), 64'hB000_0000_0000_0000 | 64'(s * 256 + k),
                    8'(1 << s));
         end
         bus.src_req_i = 3'b111;
         @(negedge clk);
         if (k == 0) begin
            chk("b_gnt_first", 64'(bus.src_gnt_o), 64'(3'b111));
            chk("b_req_first", 64'(bus.vrf_req_o), 64'(0));
         end else begin
            chk("b_src", 64'(bus.vrf_src_o), 64'(exp_src));
            chk("b_gnt", 64'(bus.src_gnt_o), 64'(1 << exp_src));
            exp_src = (exp_src + 1) % 3;
         end
         tick();
      end

      // Backpressure with every buffer full: the selected write holds still.
      bus.vrf_gnt_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         for (int s = 0; s < 3; s++) set_src(2'(s), 3'd7, 8'hCC, 64'hC0C0 + 64'(k), 8'h55);
         @(negedge clk);
         ent = peek(2'(exp_src));
         chk("c_req",  64'(bus.vrf_req_o),  64'(1));
         chk("c_src",  64'(bus.vrf_src_o),  64'(exp_src));
         chk("c_gnt",  64'(bus.src_gnt_o),  64'(0));
         chk("c_id",   64'(bus.vrf_id_o),   64'(ent.id));
         chk("c_addr", 64'(bus.vrf_addr_o), 64'(ent.addr));
         chk("c_data", bus.vrf_wdata_o,     ent.data);
         chk("c_be",   64'(bus.vrf_be_o),   64'(ent.be));
         tick();
      end
      bus.src_req_i = '0;
      bus.vrf_gnt_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("c_drain_src", 64'(bus.vrf_src_o), 64'(exp_src));
         exp_src = (exp_src + 1) % 3;
         tick();
      end
      @(negedge clk);
      chk("c_empty", 64'(bus.vrf_req_o), 64'(0));
      tick();

      // Same-cycle drain and refill of the MFPU buffer.
      bus.vrf_gnt_i = 1'b0;
      set_src(2'd1, 3'd3, 8'h21, 64'hD1, 8'h0F);
      bus.src_req_i = 3'b010;
      @(negedge clk);
      chk("d_fill_gnt", 64'(bus.src_gnt_o), 64'(3'b010));
      tick();
      bus.vrf_gnt_i = 1'b1;
      set_src(2'd1, 3'd4, 8'h22, 64'hD2, 8'hF0);
      set_src(2'd0, 3'd6, 8'h20, 64'hD0, 8'h3C);
      bus.src_req_i = 3'b011;
      @(negedge clk);
      chk("d_src", 64'(bus.vrf_src_o), 64'(1));
      chk("d_gnt", 64'(bus.src_gnt_o), 64'(3'b011));
      tick();
      bus.src_req_i = '0;
      @(negedge clk);
      chk("d_src_alu", 64'(bus.vrf_src_o), 64'(0));
      tick();
      @(negedge clk);
      chk("d_src_refill",  64'(bus.vrf_src_o), 64'(1));
      chk("d_refill_data", bus.vrf_wdata_o,    64'hD2);
      tick();
      @(negedge clk);
      chk("d_empty", 64'(bus.vrf_req_o), 64'(0));
      tick();

      // Asynchronous reset with all buffers valid and the pointer at TMAC.
      bus.vrf_gnt_i = 1'b0;
      set_src(2'd0, 3'd1, 8'h30, 64'hE0, 8'h01);
      set_src(2'd1, 3'd2, 8'h31, 64'hE1, 8'h02);
      set_src(2'd2, 3'd7, 8'h32, 64'hE2, 8'h04);
      bus.src_req_i = 3'b111;
      @(negedge clk);
      chk("e_fill_gnt", 64'(bus.src_gnt_o), 64'(3'b111));
      tick();
      bus.src_req_i = '0;
      @(negedge clk);
      chk("e_src",  64'(bus.vrf_src_o),    64'(2));
      chk("e_pend", 64'(bus.wb_pending_o), 64'(8'h86));
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("e_rst_req",  64'(bus.vrf_req_o),    64'(0));
      chk("e_rst_pend", 64'(bus.wb_pending_o), 64'(0));
      chk("e_rst_src",  64'(bus.vrf_src_o),    64'(0));
      clear_sb();
      @(posedge clk); #3;
      rst_n = 1'b1;
      bus.vrf_gnt_i = 1'b1;
      bus.src_req_i = 3'b111;
      @(negedge clk);
      chk("e_post_gnt", 64'(bus.src_gnt_o), 64'(3'b111));
      chk("e_post_req", 64'(bus.vrf_req_o), 64'(0));
      tick();
      bus.src_req_i = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("e_post_src", 64'(bus.vrf_src_o), 64'(k));
         tick();
      end

      // Same instruction ID held by ALU and TMAC.
      bus.vrf_gnt_i = 1'b0;
      set_src(2'd0, 3'd5, 8'h40, 64'hF0, 8'hAA);
      set_src(2'd2, 3'd5, 8'h42, 64'hF2, 8'hBB);
      bus.src_req_i = 3'b101;
      @(negedge clk);
      chk("f_gnt", 64'(bus.src_gnt_o), 64'(3'b101));
      tick();
      bus.src_req_i = '0;
      @(negedge clk);
      chk("f_pend", 64'(bus.wb_pending_o), 64'(8'h20));
      chk("f_src",  64'(bus.vrf_src_o),    64'(0));
      tick();
      bus.vrf_gnt_i = 1'b1;
      @(negedge clk);
      chk("f_first_src", 64'(bus.vrf_src_o), 64'(0));
      tick();
      bus.vrf_gnt_i = 1'b0;
      @(negedge clk);
      chk("f_pend_mid", 64'(bus.wb_pending_o), 64'(8'h20));
      chk("f_src_mid",  64'(bus.vrf_src_o),    64'(2));
      tick();
      bus.vrf_gnt_i = 1'b1;
      @(negedge clk);
      chk("f_pend_second", 64'(bus.wb_pending_o), 64'(8'h20));
      tick();
      @(negedge clk);
      chk("f_pend_clear", 64'(bus.wb_pending_o), 64'(0));
      chk("f_req_clear",  64'(bus.vrf_req_o),    64'(0));
      tick();

      chk("sb_leftover", 64'(q0.size() + q1.size() + q2.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
